// File: rtl/uart_rx.sv
// UART receiver (8N1 by default). Recovers bytes from the asynchronous
// uart_rxd line by sampling each bit at its midpoint, and reports good
// bytes, framing errors and line breaks as single-cycle strobes.
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int CLK_HZ       = 20_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_break,
  output logic                    uart_rx_ferr
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CW             = $clog2(CYCLES_PER_BIT);
  localparam int BW             = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e                  state_q, state_d;
  logic                    rxd_m_q, rxd_m_d;
  logic                    rxd_s_q, rxd_s_d;
  logic                    rxd_prev_q, rxd_prev_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] sr_q, sr_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    break_q, break_d;
  logic                    ferr_q, ferr_d;

  logic hit_half;
  logic hit_full;
  logic start_edge;
  logic abort;

  assign hit_half   = (cnt_q == CNT_HALF);
  assign hit_full   = (cnt_q == CNT_FULL);
  // Only a 1->0 transition arms reception, so a line held low after a break
  // cannot retrigger until it has returned high.
  assign start_edge = rxd_prev_q & ~rxd_s_q;
  assign abort      = (state_q != IDLE) && !uart_rx_en;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rxd_m_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      break_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxd_m_q    <= rxd_m_d;
      rxd_s_q    <= rxd_s_d;
      rxd_prev_q <= rxd_prev_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      break_q    <= break_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state logic: start detect, mid-bit sampling points, enable abort
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (uart_rx_en && start_edge) state_d = START;
        START: if (hit_half) state_d = rxd_s_q ? IDLE : DATA;
        DATA:  if (hit_full && (bit_q == BIT_LAST)) state_d = STOP;
        STOP:  if (hit_full) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output strobes: counters, shift register, result registers
  always_comb begin
    rxd_m_d    = uart_rxd;
    rxd_s_d    = rxd_m_q;
    rxd_prev_d = rxd_s_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sr_d       = sr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    break_d    = 1'b0;
    ferr_d     = 1'b0;
    if (abort) begin
      cnt_d = '0;
      bit_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          bit_d = '0;
        end
        START: begin
          cnt_d = hit_half ? '0 : cnt_q + 1'b1;
          bit_d = '0;
        end
        DATA: begin
          if (hit_full) begin
            cnt_d = '0;
            sr_d  = {rxd_s_q, sr_q[PAYLOAD_BITS-1:1]};
            bit_d = bit_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (hit_full) begin
            cnt_d = '0;
            if (rxd_s_q) begin
              data_d  = sr_q;
              valid_d = 1'b1;
            end else if (sr_q == '0) begin
              break_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d = '0;
          bit_d = '0;
        end
      endcase
    end
  end

  assign uart_rx_valid = valid_q;
  assign uart_rx_data  = data_q;
  assign uart_rx_break = break_q;
  assign uart_rx_ferr  = ferr_q;

endmodule
